// File: rtl/hdb3_decoder_if.sv
// ============================================================================
// Module   : hdb3_decoder_if
// Purpose  : Dual-rail HDB3 line symbols in, decoded NRZ bit and status out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hdb3_decoder_if;
    logic hdb3_p_in;
    logic hdb3_n_in;
    logic data_out;
    logic data_valid;
    logic code_err;

    modport master (
        output hdb3_p_in,
        output hdb3_n_in,
        input  data_out,
        input  data_valid,
        input  code_err
    );

    modport slave (
        input  hdb3_p_in,
        input  hdb3_n_in,
        output data_out,
        output data_valid,
        output code_err
    );
endinterface

`default_nettype wire

// File: rtl/hdb3_decoder.sv
// ============================================================================
// Module   : hdb3_decoder
// Purpose  : HDB3 receive decoder; strips B/V substitutions, flags code errors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hdb3_decoder #(
    parameter int ZRUN_MAX = 3,
    parameter bit ERR_EN   = 1'b1
) (
    input wire             clk,
    input wire             reset,
    hdb3_decoder_if.slave  bus
);

    logic w_p;
    logic w_n;
    logic w_mark;
    logic w_pol;
    logic w_is_v;
    logic w_bit;

    logic r_s1;
    logic r_s2;
    logic r_s3;
    logic r_data_out;
    logic r_data_valid;
    logic r_last_pol;
    logic r_seen_mark;
    logic [1:0] r_fill;

    assign w_p    = bus.hdb3_p_in;
    assign w_n    = bus.hdb3_n_in;
    assign w_mark = w_p ^ w_n;
    assign w_pol  = w_p;
    assign w_is_v = w_mark & r_seen_mark & (w_pol == r_last_pol);
    assign w_bit  = w_mark & ~w_is_v;

    // A V wipes the V slot and the three slots before it, covering the B of B00V.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1         <= 1'b0;
            r_s2         <= 1'b0;
            r_s3         <= 1'b0;
            r_data_out   <= 1'b0;
            r_data_valid <= 1'b0;
            r_last_pol   <= 1'b0;
            r_seen_mark  <= 1'b0;
            r_fill       <= 2'd0;
        end else begin
            if (w_is_v) begin
                r_s1       <= 1'b0;
                r_s2       <= 1'b0;
                r_s3       <= 1'b0;
                r_data_out <= 1'b0;
            end else begin
                r_s1       <= w_bit;
                r_s2       <= r_s1;
                r_s3       <= r_s2;
                r_data_out <= r_s3;
            end
            if (w_mark) begin
                r_last_pol  <= w_pol;
                r_seen_mark <= 1'b1;
            end
            if (r_fill != 2'd3) begin
                r_fill <= r_fill + 2'd1;
            end
            r_data_valid <= r_data_valid | (r_fill == 2'd2);
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;

    generate
        if (ERR_EN) begin : g_err
            localparam int                 c_RUN_W     = $clog2(ZRUN_MAX + 2);
            localparam logic [c_RUN_W-1:0] c_RUN_LIMIT = c_RUN_W'(ZRUN_MAX);
            localparam logic [c_RUN_W-1:0] c_RUN_SAT   = c_RUN_W'(ZRUN_MAX + 1);

            logic               w_space;
            logic               w_illegal;
            logic               w_overflow;
            logic [c_RUN_W-1:0] r_zero_run;
            logic               r_code_err;

            assign w_space    = ~w_p & ~w_n;
            assign w_illegal  = w_p & w_n;
            // Pulse only on the space that first crosses the limit; the counter then saturates.
            assign w_overflow = w_space & r_seen_mark & (r_zero_run == c_RUN_LIMIT);

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_zero_run <= '0;
                    r_code_err <= 1'b0;
                end else begin
                    if (w_mark) begin
                        r_zero_run <= '0;
                    end else if (w_space && r_seen_mark && (r_zero_run != c_RUN_SAT)) begin
                        r_zero_run <= r_zero_run + c_RUN_W'(1);
                    end
                    r_code_err <= w_illegal | w_overflow;
                end
            end

            assign bus.code_err = r_code_err;
        end else begin : g_no_err
            assign bus.code_err = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_hdb3_decoder.sv
// ============================================================================
// Module   : tb_hdb3_decoder
// Purpose  : Self-checking bench for hdb3_decoder (ERR_EN=1 and ERR_EN=0).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hdb3_decoder;

    localparam int ZRUN_MAX = 3;
    localparam int MAXN     = 1100;

    // symbol codes: 0 space, 1 positive mark, 2 negative mark, 3 illegal
    logic clk = 1'b0;
    logic reset;
    logic p;
    logic n;

    int pass_cnt  = 0;
    int total_cnt = 0;

    int nsym;
    int sym    [MAXN];
    bit dec    [MAXN];
    bit exp_do [MAXN];
    bit exp_dv [MAXN];
    bit exp_ce [MAXN];
    bit bits   [MAXN];

    hdb3_decoder_if bus_a ();
    hdb3_decoder_if bus_b ();

    assign bus_a.hdb3_p_in = p;
    assign bus_a.hdb3_n_in = n;
    assign bus_b.hdb3_p_in = p;
    assign bus_b.hdb3_n_in = n;

    hdb3_decoder #(.ZRUN_MAX(ZRUN_MAX), .ERR_EN(1'b1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    hdb3_decoder #(.ZRUN_MAX(ZRUN_MAX), .ERR_EN(1'b0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    always #5 clk = ~clk;

    task automatic drive(input int s);
        p = (s == 1) || (s == 3);
        n = (s == 2) || (s == 3);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        drive(0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Reference: expected outputs after each edge k, from the line-code rules.
    task automatic build_expect();
        int  last = 0;
        bit  seen = 0;
        int  run  = 0;
        bit  ovf;
        for (int k = 0; k < nsym; k++) begin
            dec[k]    = 1'b0;
            exp_ce[k] = 1'b0;
        end
        for (int k = 0; k < nsym; k++) begin
            ovf = 1'b0;
            if (sym[k] == 1 || sym[k] == 2) begin
                if (seen && sym[k] == last) begin
                    for (int j = k - 3; j <= k; j++)
                        if (j >= 0) dec[j] = 1'b0;
                end else begin
                    dec[k] = 1'b1;
                end
                last = sym[k];
                seen = 1'b1;
                run  = 0;
            end else if (sym[k] == 0) begin
                if (seen) begin
                    run++;
                    if (run == ZRUN_MAX + 1) ovf = 1'b1;
                end
            end
            exp_ce[k] = (sym[k] == 3) || ovf;
        end
        for (int k = 0; k < nsym; k++) begin
            exp_do[k] = (k >= 3) ? dec[k-3] : 1'b0;
            exp_dv[k] = (k >= 2);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(0);
        #1;
        total_cnt++; if (bus_a.data_out !== 1'b0)   $display("FAIL reset data_out: got %b want 0", bus_a.data_out);   else pass_cnt++;
        total_cnt++; if (bus_a.data_valid !== 1'b0) $display("FAIL reset data_valid: got %b want 0", bus_a.data_valid); else pass_cnt++;
        total_cnt++; if (bus_a.code_err !== 1'b0)   $display("FAIL reset code_err: got %b want 0", bus_a.code_err);   else pass_cnt++;
        apply_reset();
        // +,-,+,-,+,illegal leaves data_out=1, data_valid=1, code_err=1 after the last edge
        nsym = 6;
        sym[0] = 1; sym[1] = 2; sym[2] = 1; sym[3] = 2; sym[4] = 1; sym[5] = 3;
        for (int k = 0; k < nsym; k++) begin
            drive(sym[k]);
            @(posedge clk);
            #1;
        end
        total_cnt++; if (bus_a.data_out !== 1'b1)   $display("FAIL pre_reset data_out: got %b want 1", bus_a.data_out);   else pass_cnt++;
        total_cnt++; if (bus_a.data_valid !== 1'b1) $display("FAIL pre_reset data_valid: got %b want 1", bus_a.data_valid); else pass_cnt++;
        total_cnt++; if (bus_a.code_err !== 1'b1)   $display("FAIL pre_reset code_err: got %b want 1", bus_a.code_err);   else pass_cnt++;
        #2;
        reset = 1'b0;
        #1;
        total_cnt++; if (bus_a.data_out !== 1'b0)   $display("FAIL async_reset data_out: got %b want 0", bus_a.data_out);   else pass_cnt++;
        total_cnt++; if (bus_a.data_valid !== 1'b0) $display("FAIL async_reset data_valid: got %b want 0", bus_a.data_valid); else pass_cnt++;
        total_cnt++; if (bus_a.code_err !== 1'b0)   $display("FAIL async_reset code_err: got %b want 0", bus_a.code_err);   else pass_cnt++;
        drive(0);
        @(negedge clk);
        reset = 1'b1;
        // first mark after reset must decode as an ordinary 1 even though it repeats the old polarity
        sym[0] = 1; sym[1] = 0; sym[2] = 0; sym[3] = 0;
        for (int k = 0; k < 4; k++) begin
            drive(sym[k]);
            @(posedge clk);
            #1;
            total_cnt++;
            if (bus_a.data_valid !== (k >= 2))
                $display("FAIL release data_valid edge %0d: got %b want %b", k, bus_a.data_valid, (k >= 2));
            else pass_cnt++;
        end
        total_cnt++; if (bus_a.data_out !== 1'b1) $display("FAIL first_mark data_out: got %b want 1", bus_a.data_out); else pass_cnt++;
    endtask

    task automatic test_000v();
        bit want [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int syms [9] = '{1, 0, 0, 0, 1, 2, 0, 0, 0};
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            drive(syms[k]);
            @(posedge clk);
            #1;
            if (k >= 3) begin
                total_cnt++;
                if (bus_a.data_out !== want[k-3])
                    $display("FAIL 000v data_out edge %0d: got %b want %b", k, bus_a.data_out, want[k-3]);
                else pass_cnt++;
            end
            total_cnt++;
            if (bus_a.code_err !== 1'b0) $display("FAIL 000v code_err edge %0d: got %b want 0", k, bus_a.code_err);
            else pass_cnt++;
        end
    endtask

    task automatic test_b00v();
        bit want [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        int syms [9] = '{1, 2, 1, 0, 0, 1, 0, 0, 0};
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            drive(syms[k]);
            @(posedge clk);
            #1;
            if (k >= 3) begin
                total_cnt++;
                if (bus_a.data_out !== want[k-3])
                    $display("FAIL b00v data_out edge %0d: got %b want %b", k, bus_a.data_out, want[k-3]);
                else pass_cnt++;
            end
            total_cnt++;
            if (bus_a.code_err !== 1'b0) $display("FAIL b00v code_err edge %0d: got %b want 0", k, bus_a.code_err);
            else pass_cnt++;
        end
    endtask

    task automatic test_illegal();
        int syms [9] = '{1, 2, 3, 1, 2, 1, 0, 0, 0};
        nsym = 9;
        for (int k = 0; k < nsym; k++) sym[k] = syms[k];
        build_expect();
        apply_reset();
        for (int k = 0; k < nsym; k++) begin
            drive(sym[k]);
            @(posedge clk);
            #1;
            total_cnt++; if (bus_a.data_out !== exp_do[k]) $display("FAIL illegal data_out edge %0d: got %b want %b", k, bus_a.data_out, exp_do[k]); else pass_cnt++;
            total_cnt++; if (bus_a.code_err !== exp_ce[k]) $display("FAIL illegal code_err edge %0d: got %b want %b", k, bus_a.code_err, exp_ce[k]); else pass_cnt++;
        end
    endtask

    task automatic test_zero_run();
        int syms [20] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0};
        int pulses = 0;
        nsym = 20;
        for (int k = 0; k < nsym; k++) sym[k] = syms[k];
        build_expect();
        apply_reset();
        for (int k = 0; k < nsym; k++) begin
            drive(sym[k]);
            @(posedge clk);
            #1;
            if (bus_a.code_err === 1'b1) pulses++;
            total_cnt++; if (bus_a.code_err !== exp_ce[k]) $display("FAIL zrun code_err edge %0d: got %b want %b", k, bus_a.code_err, exp_ce[k]); else pass_cnt++;
            total_cnt++; if (bus_a.data_out !== exp_do[k]) $display("FAIL zrun data_out edge %0d: got %b want %b", k, bus_a.data_out, exp_do[k]); else pass_cnt++;
            total_cnt++; if (bus_b.code_err !== 1'b0)      $display("FAIL zrun_noerr code_err edge %0d: got %b want 0", k, bus_b.code_err); else pass_cnt++;
        end
        total_cnt++; if (pulses != 1) $display("FAIL zrun pulse_count: got %0d want 1", pulses); else pass_cnt++;
    endtask

    task automatic test_random();
        int r;
        nsym = 400;
        for (int k = 0; k < nsym; k++) begin
            r = $urandom_range(0, 9);
            sym[k] = (r < 4) ? 0 : ((r < 7) ? 1 : 2);
        end
        build_expect();
        apply_reset();
        for (int k = 0; k < nsym; k++) begin
            drive(sym[k]);
            @(posedge clk);
            #1;
            total_cnt++; if (bus_a.data_out !== exp_do[k])   $display("FAIL random data_out edge %0d: got %b want %b", k, bus_a.data_out, exp_do[k]); else pass_cnt++;
            total_cnt++; if (bus_a.data_valid !== exp_dv[k]) $display("FAIL random data_valid edge %0d: got %b want %b", k, bus_a.data_valid, exp_dv[k]); else pass_cnt++;
            total_cnt++; if (bus_a.code_err !== exp_ce[k])   $display("FAIL random code_err edge %0d: got %b want %b", k, bus_a.code_err, exp_ce[k]); else pass_cnt++;
            total_cnt++; if (bus_b.code_err !== 1'b0)        $display("FAIL random_noerr code_err edge %0d: got %b want 0", k, bus_b.code_err); else pass_cnt++;
        end
    endtask

    // Encode random NRZ bits with HDB3, decode, and compare against the source bits.
    task automatic test_round_trip();
        int lastp = 2;
        int ones  = 0;
        int zc    = 0;
        nsym = 1003;
        for (int i = 0; i < nsym; i++) bits[i] = $urandom_range(0, 1);
        for (int i = 0; i < nsym; i++) begin
            if (bits[i]) begin
                lastp  = (lastp == 1) ? 2 : 1;
                sym[i] = lastp;
                ones++;
                zc = 0;
            end else begin
                sym[i] = 0;
                zc++;
                if (zc == 4) begin
                    if (ones % 2 == 1) begin
                        sym[i] = lastp;
                    end else begin
                        lastp    = (lastp == 1) ? 2 : 1;
                        sym[i-3] = lastp;
                        sym[i]   = lastp;
                    end
                    ones = 0;
                    zc   = 0;
                end
            end
        end
        apply_reset();
        for (int k = 0; k < nsym; k++) begin
            drive(sym[k]);
            @(posedge clk);
            #1;
            if (k >= 3) begin
                total_cnt++;
                if (bus_a.data_out !== bits[k-3])
                    $display("FAIL roundtrip data_out edge %0d: got %b want %b", k, bus_a.data_out, bits[k-3]);
                else pass_cnt++;
            end
            total_cnt++;
            if (bus_a.code_err !== 1'b0) $display("FAIL roundtrip code_err edge %0d: got %b want 0", k, bus_a.code_err);
            else pass_cnt++;
        end
    endtask

    initial begin
        reset = 1'b0;
        p     = 1'b0;
        n     = 1'b0;
        test_reset();
        test_000v();
        test_b00v();
        test_illegal();
        test_zero_run();
        test_random();
        test_round_trip();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
